// File: rtl/irrigation_scheduler.sv
// Tank-fed irrigation controller: fill, sprinkler/drip irrigation, tank cleaning and fault handling.
// Cleaning is compiled in only when IRRIGATION_SCHEDULER_CLEAN_EN is defined.
module irrigation_scheduler #(
  parameter logic [7:0] SPRINKLE_TIME = 8'd20,
  parameter logic [7:0] DRIP_TIME     = 8'd60,
  parameter logic [7:0] CLEAN_TIME    = 8'd10,
  parameter logic [7:0] FILL_TIMEOUT  = 8'd120
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       tick,
  input  logic       level_low,
  input  logic       level_high,
  input  logic       soil_dry,
  input  logic       sprinkle_sel,
  input  logic       clean_req,
  output logic       inlet_valve,
  output logic       sprinkling,
  output logic       drip,
  output logic       brushes,
  output logic       outlet_valve,
  output logic       alarm,
  output logic [2:0] state,
  output logic [7:0] remaining
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FILL     = 3'd1,
    IRRIGATE = 3'd2,
    CLEAN    = 3'd3,
    FAULT    = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] rem_q, rem_d;
  logic [7:0] remDec;
  logic       mode_q, mode_d;
  logic [5:0] outs_q, outs_d;
  logic       sensErr;
`ifdef IRRIGATION_SCHEDULER_CLEAN_EN
  logic       pending_q, pending_d;
`else
  logic       unusedCleanReq;
  assign unusedCleanReq = clean_req;
`endif

  assign sensErr = level_low & level_high;
  assign remDec  = (tick && (rem_q != 8'd0)) ? (rem_q - 8'd1) : rem_q;

  // rem_d defaults to 0 so every exit edge clears the countdown
  always_comb begin
    state_d = state_q;
    rem_d   = 8'd0;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (enable) begin
          if (sensErr) begin
            state_d = FAULT;
          end else if (level_low) begin
            state_d = FILL;
            rem_d   = FILL_TIMEOUT;
          end
`ifdef IRRIGATION_SCHEDULER_CLEAN_EN
          else if (pending_q) begin
            state_d = CLEAN;
            rem_d   = CLEAN_TIME;
          end
`endif
          else if (soil_dry) begin
            state_d = IRRIGATE;
            mode_d  = sprinkle_sel;
            rem_d   = sprinkle_sel ? SPRINKLE_TIME : DRIP_TIME;
          end
        end
      end
      FILL: begin
        if (sensErr)                         state_d = FAULT;
        else if (!enable || level_high)      state_d = IDLE;
        else if (tick && rem_q == 8'd1)      state_d = FAULT;
        else                                 rem_d   = remDec;
      end
      IRRIGATE: begin
        if (sensErr)                         state_d = FAULT;
        else if (!enable || !soil_dry)       state_d = IDLE;
        else if (tick && rem_q == 8'd1)      state_d = IDLE;
        else if (level_low) begin
          state_d = FILL;
          rem_d   = FILL_TIMEOUT;
        end else                             rem_d   = remDec;
      end
`ifdef IRRIGATION_SCHEDULER_CLEAN_EN
      CLEAN: begin
        if (sensErr)                         state_d = FAULT;
        else if (!enable)                    state_d = IDLE;
        else if (tick && rem_q == 8'd1)      state_d = IDLE;
        else                                 rem_d   = remDec;
      end
`endif
      FAULT: begin
        if (!enable && !sensErr)             state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A request on the CLEAN entry edge survives so one more clean follows
`ifdef IRRIGATION_SCHEDULER_CLEAN_EN
  always_comb begin
    pending_d = pending_q | clean_req;
    if (state_d == CLEAN && state_q != CLEAN) pending_d = clean_req;
  end
`endif

  // Outputs are decoded from the next state and registered alongside it
  always_comb begin
    outs_d    = 6'b000000;
    outs_d[5] = (state_d == FILL);
    outs_d[4] = (state_d == IRRIGATE) && mode_d;
    outs_d[3] = (state_d == IRRIGATE) && !mode_d;
`ifdef IRRIGATION_SCHEDULER_CLEAN_EN
    outs_d[2] = (state_d == CLEAN);
    outs_d[1] = (state_d == CLEAN);
`endif
    outs_d[0] = (state_d == FAULT);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      rem_q     <= 8'd0;
      mode_q    <= 1'b0;
      outs_q    <= 6'b000000;
`ifdef IRRIGATION_SCHEDULER_CLEAN_EN
      pending_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      mode_q    <= mode_d;
      outs_q    <= outs_d;
`ifdef IRRIGATION_SCHEDULER_CLEAN_EN
      pending_q <= pending_d;
`endif
    end
  end

  assign inlet_valve  = outs_q[5];
  assign sprinkling   = outs_q[4];
  assign drip         = outs_q[3];
  assign brushes      = outs_q[2];
  assign outlet_valve = outs_q[1];
  assign alarm        = outs_q[0];
  assign state        = state_q;
  assign remaining    = rem_q;

endmodule

// File: tb/tb_irrigation_scheduler.sv
// Scoreboard bench for irrigation_scheduler with short timing parameters.
// Clean-related vectors follow IRRIGATION_SCHEDULER_CLEAN_EN, matching the RTL build.
module tb_irrigation_scheduler;

  logic       clock = 1'b0;
  logic       reset, enable, tick, level_low, level_high, soil_dry, sprinkle_sel, clean_req;
  logic       inlet_valve, sprinkling, drip, brushes, outlet_valve, alarm;
  logic [2:0] state;
  logic [7:0] remaining;

  typedef struct packed {
    logic [2:0] st;
    logic [7:0] rem;
    logic [5:0] outs;
    logic [7:0] phase;
    logic [7:0] step;
  } exp_t;

  exp_t sbQ[$];
  int   total = 0;
  int   bad   = 0;
  int   phase = 0;
  int   stepNo = 0;

  localparam logic [5:0] O_NONE  = 6'b000000;
  localparam logic [5:0] O_FILL  = 6'b100000;
  localparam logic [5:0] O_SPR   = 6'b010000;
  localparam logic [5:0] O_DRIP  = 6'b001000;
  localparam logic [5:0] O_CLEAN = 6'b000110;
  localparam logic [5:0] O_ALARM = 6'b000001;

  irrigation_scheduler #(
    .SPRINKLE_TIME(8'd4),
    .DRIP_TIME    (8'd6),
    .CLEAN_TIME   (8'd3),
    .FILL_TIMEOUT (8'd5)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .tick        (tick),
    .level_low   (level_low),
    .level_high  (level_high),
    .soil_dry    (soil_dry),
    .sprinkle_sel(sprinkle_sel),
    .clean_req   (clean_req),
    .inlet_valve (inlet_valve),
    .sprinkling  (sprinkling),
    .drip        (drip),
    .brushes     (brushes),
    .outlet_valve(outlet_valve),
    .alarm       (alarm),
    .state       (state),
    .remaining   (remaining)
  );

  always #5 clock = ~clock;

  function automatic string phaseName(input logic [7:0] p);
    case (p)
      8'd0:    return "reset";
      8'd1:    return "sprinkle";
      8'd2:    return "drip_latch";
      8'd3:    return "fill_timeout";
      8'd4:    return "fill_full";
      8'd5:    return "enable_off";
      8'd6:    return "reset_mid";
      8'd7:    return "sensor_err";
      8'd8:    return "clean_prio";
      8'd9:    return "clean_edge";
      8'd10:   return "clean_off";
      default: return "other";
    endcase
  endfunction

  // vec = {reset, enable, tick, level_low, level_high, soil_dry, sprinkle_sel, clean_req}
  task automatic applyStimulus(input logic [7:0] vec, input logic [2:0] st,
                               input logic [7:0] rem, input logic [5:0] outs);
    exp_t e;
    {reset, enable, tick, level_low, level_high, soil_dry, sprinkle_sel, clean_req} = vec;
    @(posedge clock);
    #1;
    e.st    = st;
    e.rem   = rem;
    e.outs  = outs;
    e.phase = 8'(phase);
    e.step  = 8'(stepNo);
    sbQ.push_back(e);
    stepNo++;
  endtask

  task automatic checkOutput(input exp_t e);
    logic [5:0] act;
    act = {inlet_valve, sprinkling, drip, brushes, outlet_valve, alarm};
    total++;
    if (state !== e.st || remaining !== e.rem || act !== e.outs) begin
      bad++;
      $display("[TB] FAIL %s step %0d: got state=%0d rem=%0d outs=%b, want state=%0d rem=%0d outs=%b",
               phaseName(e.phase), e.step, state, remaining, act, e.st, e.rem, e.outs);
    end
    total++;
    if ($countones({inlet_valve, sprinkling, drip, brushes}) > 1) begin
      bad++;
      $display("[TB] FAIL %s step %0d exclusive: got valves=%b, want at most one set",
               phaseName(e.phase), e.step, {inlet_valve, sprinkling, drip, brushes});
    end
  endtask

  // Monitor: each cycle that carries an expectation is checked on the falling edge
  always @(negedge clock) begin
    if (sbQ.size() > 0) checkOutput(sbQ.pop_front());
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, want finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    {reset, enable, tick, level_low, level_high, soil_dry, sprinkle_sel, clean_req} = 8'h80;

    phase = 0;
    applyStimulus(8'b1000_0000, 3'd0, 8'd0, O_NONE);
    applyStimulus(8'b1110_0111, 3'd0, 8'd0, O_NONE);

    phase = 1;
    applyStimulus(8'b0110_0110, 3'd2, 8'd4, O_SPR);
    applyStimulus(8'b0110_0110, 3'd2, 8'd3, O_SPR);
    applyStimulus(8'b0110_0110, 3'd2, 8'd2, O_SPR);
    applyStimulus(8'b0110_0110, 3'd2, 8'd1, O_SPR);
    applyStimulus(8'b0110_0110, 3'd0, 8'd0, O_NONE);
    applyStimulus(8'b0100_0000, 3'd0, 8'd0, O_NONE);

    phase = 2;
    applyStimulus(8'b0100_0100, 3'd2, 8'd6, O_DRIP);
    applyStimulus(8'b0110_0110, 3'd2, 8'd5, O_DRIP);
    applyStimulus(8'b0110_0110, 3'd2, 8'd4, O_DRIP);
    applyStimulus(8'b0101_0110, 3'd1, 8'd5, O_FILL);

    phase = 3;
    applyStimulus(8'b0111_0000, 3'd1, 8'd4, O_FILL);
    applyStimulus(8'b0111_0000, 3'd1, 8'd3, O_FILL);
    applyStimulus(8'b0111_0000, 3'd1, 8'd2, O_FILL);
    applyStimulus(8'b0111_0000, 3'd1, 8'd1, O_FILL);
    applyStimulus(8'b0111_0000, 3'd4, 8'd0, O_ALARM);
    applyStimulus(8'b0100_0000, 3'd4, 8'd0, O_ALARM);
    applyStimulus(8'b0000_0000, 3'd0, 8'd0, O_NONE);

    phase = 4;
    applyStimulus(8'b0101_0000, 3'd1, 8'd5, O_FILL);
    applyStimulus(8'b0110_1000, 3'd0, 8'd0, O_NONE);
    applyStimulus(8'b0000_0000, 3'd0, 8'd0, O_NONE);

    phase = 5;
    applyStimulus(8'b0100_0110, 3'd2, 8'd4, O_SPR);
    applyStimulus(8'b0000_0110, 3'd0, 8'd0, O_NONE);

    phase = 6;
    applyStimulus(8'b0100_0100, 3'd2, 8'd6, O_DRIP);
    applyStimulus(8'b1110_0100, 3'd0, 8'd0, O_NONE);
    applyStimulus(8'b0000_0000, 3'd0, 8'd0, O_NONE);
    applyStimulus(8'b0101_0000, 3'd1, 8'd5, O_FILL);
    applyStimulus(8'b1101_0000, 3'd0, 8'd0, O_NONE);
    applyStimulus(8'b0000_0000, 3'd0, 8'd0, O_NONE);

    phase = 7;
    applyStimulus(8'b0101_1000, 3'd4, 8'd0, O_ALARM);
    applyStimulus(8'b0001_1000, 3'd4, 8'd0, O_ALARM);
    applyStimulus(8'b0000_0000, 3'd0, 8'd0, O_NONE);
    applyStimulus(8'b0100_0110, 3'd2, 8'd4, O_SPR);
    applyStimulus(8'b0101_1110, 3'd4, 8'd0, O_ALARM);
    applyStimulus(8'b0000_0000, 3'd0, 8'd0, O_NONE);

`ifdef IRRIGATION_SCHEDULER_CLEAN_EN
    phase = 8;
    applyStimulus(8'b0110_0110, 3'd2, 8'd4, O_SPR);
    applyStimulus(8'b0110_0111, 3'd2, 8'd3, O_SPR);
    applyStimulus(8'b0110_0111, 3'd2, 8'd2, O_SPR);
    applyStimulus(8'b0110_0110, 3'd2, 8'd1, O_SPR);
    applyStimulus(8'b0110_0110, 3'd0, 8'd0, O_NONE);
    applyStimulus(8'b0110_0110, 3'd3, 8'd3, O_CLEAN);
    applyStimulus(8'b0110_0110, 3'd3, 8'd2, O_CLEAN);
    applyStimulus(8'b0110_0110, 3'd3, 8'd1, O_CLEAN);
    applyStimulus(8'b0110_0110, 3'd0, 8'd0, O_NONE);
    applyStimulus(8'b0110_0110, 3'd2, 8'd4, O_SPR);
    applyStimulus(8'b0000_0000, 3'd0, 8'd0, O_NONE);

    phase = 9;
    applyStimulus(8'b0000_0001, 3'd0, 8'd0, O_NONE);
    applyStimulus(8'b0100_0001, 3'd3, 8'd3, O_CLEAN);
    applyStimulus(8'b0101_1000, 3'd4, 8'd0, O_ALARM);
    applyStimulus(8'b0000_0000, 3'd0, 8'd0, O_NONE);
    applyStimulus(8'b0100_0000, 3'd3, 8'd3, O_CLEAN);
    applyStimulus(8'b0111_0100, 3'd3, 8'd2, O_CLEAN);
    applyStimulus(8'b0110_0000, 3'd3, 8'd1, O_CLEAN);
    applyStimulus(8'b0110_0000, 3'd0, 8'd0, O_NONE);
    applyStimulus(8'b0100_0000, 3'd0, 8'd0, O_NONE);
`else
    phase = 10;
    applyStimulus(8'b0000_0001, 3'd0, 8'd0, O_NONE);
    applyStimulus(8'b0100_0000, 3'd0, 8'd0, O_NONE);
    applyStimulus(8'b0100_0001, 3'd0, 8'd0, O_NONE);
    applyStimulus(8'b0100_0110, 3'd2, 8'd4, O_SPR);
    applyStimulus(8'b0000_0000, 3'd0, 8'd0, O_NONE);
    applyStimulus(8'b0100_0000, 3'd0, 8'd0, O_NONE);
`endif

    repeat (3) @(negedge clock);
    total++;
    if (sbQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain: got %0d pending expectations, want 0", sbQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
